mips_mc_control: RTL

//  Multi-cycle MIPS control FSM; the initiator that drives the ALU. Decodes OPCODE/FUNCT,

---
 rtl/mips_mc_control_pkg.sv | 89 ++++++++
 rtl/mips_mc_control_alu_op_decode.sv | 40 ++++
 rtl/mips_mc_control.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/mips_mc_control_pkg.sv
// Shared constants, state encoding and decode helpers for the multi-cycle MIPS control FSM.
package mips_mc_control_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] F_SLL  = 6'h00;
    localparam logic [5:0] F_ADD  = 6'h20;
    localparam logic [5:0] F_ADDU = 6'h21;
    localparam logic [5:0] F_SUB  = 6'h22;
    localparam logic [5:0] F_SUBU = 6'h23;
    localparam logic [5:0] F_AND  = 6'h24;
    localparam logic [5:0] F_OR   = 6'h25;
    localparam logic [5:0] F_XOR  = 6'h26;
    localparam logic [5:0] F_NOR  = 6'h27;
    localparam logic [5:0] F_SLT  = 6'h2A;

    localparam logic [2:0] ALU_AND = 3'd0;
    localparam logic [2:0] ALU_OR  = 3'd1;
    localparam logic [2:0] ALU_XOR = 3'd2;
    localparam logic [2:0] ALU_NOR = 3'd3;
    localparam logic [2:0] ALU_ADD = 3'd4;
    localparam logic [2:0] ALU_SUB = 3'd5;
    localparam logic [2:0] ALU_SLT = 3'd6;
    localparam logic [2:0] ALU_SLL = 3'd7;

    localparam logic [1:0] PCS_ALU    = 2'd0;
    localparam logic [1:0] PCS_ALUOUT = 2'd1;
    localparam logic [1:0] PCS_JUMP   = 2'd2;

    localparam logic [1:0] SRCB_RT   = 2'd0;
    localparam logic [1:0] SRCB_FOUR = 2'd1;
    localparam logic [1:0] SRCB_IMM  = 2'd2;
    localparam logic [1:0] SRCB_BR   = 2'd3;

    typedef enum logic [3:0] {
        ST_FETCH   = 4'd0,
        ST_DECODE  = 4'd1,
        ST_EXEC_R  = 4'd2,
        ST_EXEC_I  = 4'd3,
        ST_WB_R    = 4'd4,
        ST_WB_I    = 4'd5,
        ST_ADDR    = 4'd6,
        ST_MEM_RD  = 4'd7,
        ST_MEM_WR  = 4'd8,
        ST_MEM_WB  = 4'd9,
        ST_BRANCH  = 4'd10,
        ST_JUMP    = 4'd11,
        ST_ILLEGAL = 4'd12
    } state_t;

    typedef enum logic [1:0] {
        CLS_ADD = 2'd0,
        CLS_SUB = 2'd1,
        CLS_R   = 2'd2,
        CLS_I   = 2'd3
    } alu_cls_t;

    function automatic logic funct_legal(input logic [5:0] funct);
        case (funct)
            F_SLL, F_ADD, F_ADDU, F_SUB, F_SUBU,
            F_AND, F_OR, F_XOR, F_NOR, F_SLT: return 1'b1;
            default:                          return 1'b0;
        endcase
    endfunction

    function automatic state_t decode_next(input logic [5:0] opcode, input logic [5:0] funct);
        case (opcode)
            OP_RTYPE:                       return funct_legal(funct) ? ST_EXEC_R : ST_ILLEGAL;
            OP_ADDI, OP_ADDIU, OP_SLTI,
            OP_ANDI, OP_ORI, OP_XORI:       return ST_EXEC_I;
            OP_LW, OP_SW:                   return ST_ADDR;
            OP_BEQ, OP_BNE:                 return ST_BRANCH;
            OP_J:                           return ST_JUMP;
            default:                        return ST_ILLEGAL;
        endcase
    endfunction

endpackage

// File: rtl/mips_mc_control_alu_op_decode.sv
// Maps the FSM's ALU usage class plus OPCODE/FUNCT onto the 3-bit ALU operation code.
module mips_mc_control_alu_op_decode
    import mips_mc_control_pkg::*;
(
    input  alu_cls_t   cls,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output logic [2:0] alu_op
);

    always_comb begin
        alu_op = ALU_ADD;
        case (cls)
            CLS_SUB: alu_op = ALU_SUB;
            CLS_R: begin
                case (funct)
                    F_SUB, F_SUBU: alu_op = ALU_SUB;
                    F_AND:         alu_op = ALU_AND;
                    F_OR:          alu_op = ALU_OR;
                    F_XOR:         alu_op = ALU_XOR;
                    F_NOR:         alu_op = ALU_NOR;
                    F_SLT:         alu_op = ALU_SLT;
                    F_SLL:         alu_op = ALU_SLL;
                    default:       alu_op = ALU_ADD;
                endcase
            end
            CLS_I: begin
                case (opcode)
                    OP_SLTI: alu_op = ALU_SLT;
                    OP_ANDI: alu_op = ALU_AND;
                    OP_ORI:  alu_op = ALU_OR;
                    OP_XORI: alu_op = ALU_XOR;
                    default: alu_op = ALU_ADD;
                endcase
            end
            default: alu_op = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mips_mc_control.sv
// Multi-cycle MIPS control FSM driving ALU selects, memory and register-file strobes.
// Defining OVF_TRAP_EN turns signed add overflow into an exception in writeback.
module mips_mc_control
    import mips_mc_control_pkg::*;
#(
    parameter logic [1:0] EXC_VEC_SEL = 2'd3
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [5:0] OPCODE,
    input  logic [5:0] FUNCT,
    input  logic       ZF,
    input  logic       OF,
    input  logic       MEM_READY,
    output logic [2:0] ALU_OP,
    output logic       ALU_SRC_A,
    output logic [1:0] ALU_SRC_B,
    output logic       IORD,
    output logic       MEM_READ,
    output logic       MEM_WRITE,
    output logic       IR_WRITE,
    output logic       PC_WRITE,
    output logic       REG_WRITE,
    output logic       REG_DST,
    output logic       MEM_TO_REG,
    output logic [1:0] PC_SRC,
    output logic       EXC,
    output logic       EXC_CAUSE,
    output logic [3:0] STATE
);

    state_t   state;
    alu_cls_t alu_cls;
    logic     trap;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= ST_FETCH;
        end else begin
            case (state)
                ST_FETCH:  if (MEM_READY) state <= ST_DECODE;
                ST_DECODE: state <= decode_next(OPCODE, FUNCT);
                ST_EXEC_R: state <= ST_WB_R;
                ST_EXEC_I: state <= ST_WB_I;
                ST_ADDR:   state <= (OPCODE == OP_SW) ? ST_MEM_WR : ST_MEM_RD;
                ST_MEM_RD: if (MEM_READY) state <= ST_MEM_WB;
                ST_MEM_WR: if (MEM_READY) state <= ST_FETCH;
                default:   state <= ST_FETCH;
            endcase
        end
    end

`ifdef OVF_TRAP_EN
    logic ovf_q;

    // Only signed add/sub (R) and addi can trap; unsigned forms never do.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)
            ovf_q <= 1'b0;
        else if (state == ST_EXEC_R)
            ovf_q <= OF & ((FUNCT == F_ADD) || (FUNCT == F_SUB));
        else if (state == ST_EXEC_I)
            ovf_q <= OF & (OPCODE == OP_ADDI);
    end

    assign trap = ovf_q;
`else
    logic unused_of;

    assign unused_of = OF;
    assign trap      = 1'b0;
`endif

    assign STATE = state;

    always_comb begin
        alu_cls = CLS_ADD;
        case (state)
            ST_EXEC_R: alu_cls = CLS_R;
            ST_EXEC_I: alu_cls = CLS_I;
            ST_BRANCH: alu_cls = CLS_SUB;
            default:   alu_cls = CLS_ADD;
        endcase
    end

    mips_mc_control_alu_op_decode u_alu_op_decode (
        .cls    (alu_cls),
        .opcode (OPCODE),
        .funct  (FUNCT),
        .alu_op (ALU_OP)
    );

    // Strobes are forced idle while reset is asserted, independent of MEM_READY.
    always_comb begin
        ALU_SRC_A  = 1'b0;
        ALU_SRC_B  = SRCB_RT;
        IORD       = 1'b0;
        MEM_READ   = 1'b0;
        MEM_WRITE  = 1'b0;
        IR_WRITE   = 1'b0;
        PC_WRITE   = 1'b0;
        REG_WRITE  = 1'b0;
        REG_DST    = 1'b0;
        MEM_TO_REG = 1'b0;
        PC_SRC     = PCS_ALU;
        EXC        = 1'b0;
        EXC_CAUSE  = 1'b0;
        if (RST_N) begin
            case (state)
                ST_FETCH: begin
                    MEM_READ  = 1'b1;
                    ALU_SRC_B = SRCB_FOUR;
                    IR_WRITE  = MEM_READY;
                    PC_WRITE  = MEM_READY;
                end
                ST_DECODE: ALU_SRC_B = SRCB_BR;
                ST_EXEC_R: ALU_SRC_A = 1'b1;
                ST_EXEC_I, ST_ADDR: begin
                    ALU_SRC_A = 1'b1;
                    ALU_SRC_B = SRCB_IMM;
                end
                ST_WB_R, ST_WB_I: begin
                    REG_DST = (state == ST_WB_R);
                    if (trap) begin
                        EXC       = 1'b1;
                        EXC_CAUSE = 1'b1;
                        PC_SRC    = EXC_VEC_SEL;
                        PC_WRITE  = 1'b1;
                    end else begin
                        REG_WRITE = 1'b1;
                    end
                end
                ST_MEM_RD: begin
                    MEM_READ = 1'b1;
                    IORD     = 1'b1;
                end
                ST_MEM_WR: begin
                    MEM_WRITE = 1'b1;
                    IORD      = 1'b1;
                end
                ST_MEM_WB: begin
                    REG_WRITE  = 1'b1;
                    MEM_TO_REG = 1'b1;
                end
                ST_BRANCH: begin
                    ALU_SRC_A = 1'b1;
                    PC_SRC    = PCS_ALUOUT;
                    PC_WRITE  = (OPCODE == OP_BEQ) ? ZF : ~ZF;
                end
                ST_JUMP: begin
                    PC_SRC   = PCS_JUMP;
                    PC_WRITE = 1'b1;
                end
                ST_ILLEGAL: begin
                    EXC      = 1'b1;
                    PC_SRC   = EXC_VEC_SEL;
                    PC_WRITE = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
